// File: rtl/regfile_arbiter_if.sv
// Requester-side handshake bundle for regfile_arbiter.
// The master modport is the requester, the slave modport is the arbiter.
interface regfile_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;

    modport master (
        output req, we, waddr, wdata, raddr_a, raddr_b,
        input  gnt, rvalid, rdata_a, rdata_b
    );

    modport slave (
        input  req, we, waddr, wdata, raddr_a, raddr_b,
        output gnt, rvalid, rdata_a, rdata_b
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a register file with one
// write port and two combinational read ports. A transaction is captured,
// issued to the regfile for one cycle, then its read data is returned for
// one cycle. Only one transaction is in flight at a time.
module regfile_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_arbiter_if.slave      r0_if,
    regfile_arbiter_if.slave      r1_if,
    output logic                  ctrl_write_enable_o,
    output logic [ADDR_WIDTH-1:0] ctrl_write_reg_o,
    output logic [ADDR_WIDTH-1:0] ctrl_read_reg_a_o,
    output logic [ADDR_WIDTH-1:0] ctrl_read_reg_b_o,
    output logic [DATA_WIDTH-1:0] data_write_reg_o,
    input  logic [DATA_WIDTH-1:0] data_read_reg_a_i,
    input  logic [DATA_WIDTH-1:0] data_read_reg_b_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Round-robin pointer and the requester owning the in-flight transaction
    logic prio_q, prio_d;
    logic win_q, win_d;

    // Captured transaction fields
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] raddr_a_q;
    logic [ADDR_WIDTH-1:0] raddr_b_q;

    // Requester views indexed by requester number
    logic [1:0]                 req_w;
    logic [1:0]                 we_w;
    logic [1:0][ADDR_WIDTH-1:0] waddr_w;
    logic [1:0][DATA_WIDTH-1:0] wdata_w;
    logic [1:0][ADDR_WIDTH-1:0] raddr_a_w;
    logic [1:0][ADDR_WIDTH-1:0] raddr_b_w;

    logic [1:0]                 gnt_w;
    logic [1:0]                 rvalid_w;
    logic [DATA_WIDTH-1:0]      rdata_a_q [2];
    logic [DATA_WIDTH-1:0]      rdata_b_q [2];

    logic sel;
    logic capture;

    assign req_w     = {r1_if.req, r0_if.req};
    assign we_w      = {r1_if.we, r0_if.we};
    assign waddr_w   = {r1_if.waddr, r0_if.waddr};
    assign wdata_w   = {r1_if.wdata, r0_if.wdata};
    assign raddr_a_w = {r1_if.raddr_a, r0_if.raddr_a};
    assign raddr_b_w = {r1_if.raddr_b, r0_if.raddr_b};

    // Winner: the sole requester, or the pointer's choice when both ask
    always_comb begin
        sel = 1'b0;
        if (req_w == 2'b11) begin
            sel = prio_q;
        end else begin
            sel = req_w[1];
        end
    end

    // Next-state logic; arbitration happens only in IDLE and RESP
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win_d   = win_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (|req_w) begin
                    capture = 1'b1;
                    win_d   = sel;
                    prio_d  = ~sel;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
        end
    end

    // Capture the winning request's fields so requesters may change them later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
        end else if (capture) begin
            we_q      <= we_w[sel];
            waddr_q   <= waddr_w[sel];
            wdata_q   <= wdata_w[sel];
            raddr_a_q <= raddr_a_w[sel];
            raddr_b_q <= raddr_b_w[sel];
        end
    end

    // Regfile controls are driven only while issuing; register 0 is never written
    always_comb begin
        ctrl_write_enable_o = 1'b0;
        ctrl_write_reg_o    = '0;
        ctrl_read_reg_a_o   = '0;
        ctrl_read_reg_b_o   = '0;
        data_write_reg_o    = '0;
        if (state_q == ST_ISSUE) begin
            ctrl_write_enable_o = we_q && (waddr_q != '0);
            ctrl_write_reg_o    = waddr_q;
            ctrl_read_reg_a_o   = raddr_a_q;
            ctrl_read_reg_b_o   = raddr_b_q;
            data_write_reg_o    = wdata_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_w[gi]    = (state_q == ST_ISSUE) && (win_q == 1'(gi));
            assign rvalid_w[gi] = (state_q == ST_RESP) && (win_q == 1'(gi));

            // Read results land at the end of the issue cycle and hold until the next one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_a_q[gi] <= '0;
                    rdata_b_q[gi] <= '0;
                end else if (gnt_w[gi]) begin
                    rdata_a_q[gi] <= data_read_reg_a_i;
                    rdata_b_q[gi] <= data_read_reg_b_i;
                end
            end
        end
    endgenerate

    assign r0_if.gnt     = gnt_w[0];
    assign r0_if.rvalid  = rvalid_w[0];
    assign r0_if.rdata_a = rdata_a_q[0];
    assign r0_if.rdata_b = rdata_b_q[0];
    assign r1_if.gnt     = gnt_w[1];
    assign r1_if.rvalid  = rvalid_w[1];
    assign r1_if.rdata_a = rdata_a_q[1];
    assign r1_if.rdata_b = rdata_b_q[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios followed by random traffic
// checked against a transaction-level model of the register file and the
// round-robin rule.
module tb_regfile_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) r0_if ();
    regfile_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) r1_if ();

    logic        ctrl_we;
    logic [4:0]  ctrl_wreg, ctrl_rreg_a, ctrl_rreg_b;
    logic [31:0] data_wreg, data_rreg_a, data_rreg_b;

    regfile_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r0_if               (r0_if),
        .r1_if               (r1_if),
        .ctrl_write_enable_o (ctrl_we),
        .ctrl_write_reg_o    (ctrl_wreg),
        .ctrl_read_reg_a_o   (ctrl_rreg_a),
        .ctrl_read_reg_b_o   (ctrl_rreg_b),
        .data_write_reg_o    (data_wreg),
        .data_read_reg_a_i   (data_rreg_a),
        .data_read_reg_b_i   (data_rreg_b)
    );

    // Environment register file: combinational reads, write on clock edge
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ctrl_we) rf[ctrl_wreg] <= data_wreg;
    end
    assign data_rreg_a = rf[ctrl_rreg_a];
    assign data_rreg_b = rf[ctrl_rreg_b];

    // Requester drive variables
    logic        tb_req [2];
    logic        tb_we [2];
    logic [4:0]  tb_waddr [2];
    logic [31:0] tb_wdata [2];
    logic [4:0]  tb_ra [2];
    logic [4:0]  tb_rb [2];

    assign r0_if.req = tb_req[0];  assign r1_if.req = tb_req[1];
    assign r0_if.we = tb_we[0];    assign r1_if.we = tb_we[1];
    assign r0_if.waddr = tb_waddr[0]; assign r1_if.waddr = tb_waddr[1];
    assign r0_if.wdata = tb_wdata[0]; assign r1_if.wdata = tb_wdata[1];
    assign r0_if.raddr_a = tb_ra[0];  assign r1_if.raddr_a = tb_ra[1];
    assign r0_if.raddr_b = tb_rb[0];  assign r1_if.raddr_b = tb_rb[1];

    logic        gnt [2];
    logic        rvalid [2];
    logic [31:0] rda [2];
    logic [31:0] rdb [2];
    assign gnt[0] = r0_if.gnt;        assign gnt[1] = r1_if.gnt;
    assign rvalid[0] = r0_if.rvalid;  assign rvalid[1] = r1_if.rvalid;
    assign rda[0] = r0_if.rdata_a;    assign rda[1] = r1_if.rdata_a;
    assign rdb[0] = r0_if.rdata_b;    assign rdb[1] = r1_if.rdata_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic [31:0] ref_mem [32];
    int          mprio;
    int          last_gnt;
    int          prev_g;
    logic [31:0] exp_rda, exp_rdb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, "_we"}, 32'(ctrl_we), 32'h0);
        chk({tag, "_wreg"}, 32'(ctrl_wreg), 32'h0);
        chk({tag, "_rrega"}, 32'(ctrl_rreg_a), 32'h0);
        chk({tag, "_rregb"}, 32'(ctrl_rreg_b), 32'h0);
        chk({tag, "_wdata"}, data_wreg, 32'h0);
    endtask

    task automatic chk_hs(input string tag, input logic g0, input logic g1,
                          input logic v0, input logic v1);
        chk({tag, "_gnt0"}, 32'(gnt[0]), 32'(g0));
        chk({tag, "_gnt1"}, 32'(gnt[1]), 32'(g1));
        chk({tag, "_rvalid0"}, 32'(rvalid[0]), 32'(v0));
        chk({tag, "_rvalid1"}, 32'(rvalid[1]), 32'(v1));
    endtask

    task automatic set_req(input int i, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        tb_req[i] = 1'b1; tb_we[i] = we; tb_waddr[i] = wa;
        tb_wdata[i] = wd; tb_ra[i] = ra; tb_rb[i] = rb;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    // Reset: everything must drop immediately, released away from a clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tb_req[0] = 1'b0; tb_req[1] = 1'b0;
        #1;
        chk_hs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl_zero(tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_rda"}, rda[i], 32'h0);
            chk({tag, "_rdb"}, rdb[i], 32'h0);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        mprio = 0;
        last_gnt = -10;
        prev_g = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g, old_prev;
        for (int i = 0; i < 2; i++) begin
            tb_req[i] = 1'b0; tb_we[i] = 1'b0; tb_waddr[i] = '0;
            tb_wdata[i] = '0; tb_ra[i] = '0; tb_rb[i] = '0;
        end
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

        do_reset("rst0");

        // r0 write of 0000DEAD to register 5
        set_req(0, 1'b1, 5'd5, 32'h0000DEAD, 5'd0, 5'd0);
        tick();
        chk_hs("wr5_issue", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wr5_we", 32'(ctrl_we), 32'h1);
        chk("wr5_wreg", 32'(ctrl_wreg), 32'd5);
        chk("wr5_wdata", data_wreg, 32'h0000DEAD);
        tick();
        chk_hs("wr5_resp", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wr5_resp_we", 32'(ctrl_we), 32'h0);
        tb_req[0] = 1'b0;
        ref_mem[5] = 32'h0000DEAD;
        tick();
        chk_hs("wr5_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl_zero("wr5_idle");

        // r1 read of registers 5 and 0
        set_req(1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        tick();
        chk_hs("rd5_issue", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rd5_we", 32'(ctrl_we), 32'h0);
        chk("rd5_rrega", 32'(ctrl_rreg_a), 32'd5);
        tick();
        chk_hs("rd5_resp", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rd5_rda", rda[1], 32'h0000DEAD);
        chk("rd5_rdb", rdb[1], 32'h0);
        chk("rd5_resp_we", 32'(ctrl_we), 32'h0);
        tb_req[1] = 1'b0;
        tick();

        // Simultaneous requests after reset, both held: grants alternate 0,1,0,1
        do_reset("rst1");
        set_req(0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        set_req(1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t % 2 == 1) begin
                chk_hs("alt_issue", ((t - 1) / 2) % 2 == 0, ((t - 1) / 2) % 2 == 1, 1'b0, 1'b0);
            end else begin
                chk_hs("alt_resp", 1'b0, 1'b0, ((t - 2) / 2) % 2 == 0, ((t - 2) / 2) % 2 == 1);
                if (((t - 2) / 2) % 2 == 0) chk("alt_rda0", rda[0], 32'h0000DEAD);
                else chk("alt_rdb1", rdb[1], 32'h0000DEAD);
            end
        end
        tb_req[0] = 1'b0; tb_req[1] = 1'b0;
        tick();
        chk_hs("alt_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Write to register 0 is granted but never enables the regfile write
        set_req(0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        chk_hs("wr0_issue", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wr0_we_issue", 32'(ctrl_we), 32'h0);
        tick();
        chk_hs("wr0_resp", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wr0_we_resp", 32'(ctrl_we), 32'h0);
        tb_req[0] = 1'b0;
        tick();

        // Reset asserted in the middle of a write issue to register 7
        set_req(0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
        tick();
        chk("abort_we_before", 32'(ctrl_we), 32'h1);
        chk("abort_gnt_before", 32'(gnt[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_hs("abort_now", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl_zero("abort_now");
        tb_req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mprio = 0; last_gnt = -10; prev_g = -1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk_hs("abort_after", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("abort_rf7", rf[7], ref_mem[7]);

        // Single requester holding req: back-to-back issue/response, no idle gap
        set_req(1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t % 2 == 1) begin
                chk_hs("hold_issue", 1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                chk_hs("hold_resp", 1'b0, 1'b0, 1'b0, 1'b1);
                chk("hold_rda", rda[1], 32'h0000DEAD);
            end
        end
        tb_req[1] = 1'b0;
        tick();

        // Random traffic against the transaction model
        do_reset("rst2");
        for (int n = 0; n < 400; n++) begin
            tick();
            exp_g = -1;
            if (last_gnt != cyc - 1 && (tb_req[0] || tb_req[1])) begin
                if (tb_req[0] && tb_req[1]) exp_g = mprio;
                else exp_g = tb_req[1] ? 1 : 0;
                mprio = 1 - exp_g;
                last_gnt = cyc;
            end
            chk("rnd_gnt0", 32'(gnt[0]), 32'(exp_g == 0));
            chk("rnd_gnt1", 32'(gnt[1]), 32'(exp_g == 1));
            chk("rnd_rvalid0", 32'(rvalid[0]), 32'(prev_g == 0));
            chk("rnd_rvalid1", 32'(rvalid[1]), 32'(prev_g == 1));
            if (prev_g >= 0) begin
                chk("rnd_rda", rda[prev_g], exp_rda);
                chk("rnd_rdb", rdb[prev_g], exp_rdb);
            end
            if (exp_g >= 0) begin
                chk("rnd_we", 32'(ctrl_we), 32'(tb_we[exp_g] && tb_waddr[exp_g] != 5'd0));
                chk("rnd_wreg", 32'(ctrl_wreg), 32'(tb_waddr[exp_g]));
                chk("rnd_wdata", data_wreg, tb_wdata[exp_g]);
                chk("rnd_rrega", 32'(ctrl_rreg_a), 32'(tb_ra[exp_g]));
                chk("rnd_rregb", 32'(ctrl_rreg_b), 32'(tb_rb[exp_g]));
                exp_rda = ref_mem[tb_ra[exp_g]];
                exp_rdb = ref_mem[tb_rb[exp_g]];
                if (tb_we[exp_g] && tb_waddr[exp_g] != 5'd0)
                    ref_mem[tb_waddr[exp_g]] = tb_wdata[exp_g];
            end else begin
                chk("rnd_quiet_we", 32'(ctrl_we), 32'h0);
                chk("rnd_quiet_wreg", 32'(ctrl_wreg), 32'h0);
            end
            old_prev = prev_g;
            prev_g = exp_g;
            for (int i = 0; i < 2; i++) begin
                if (i == old_prev) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else tb_req[i] = 1'b0;
                end else if (!tb_req[i]) begin
                    if ($urandom_range(0, 2) == 0) rand_req(i);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
